// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 3-stage pipeline hazard controller.
package pipe_ctrl_pkg;

   localparam int REG_AW_DEFAULT = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FAULT = 2'd2
   } mem_state_t;

   // Operand mux selects: register-file read or MW writeback value
   localparam logic FWD_REG = 1'b0;
   localparam logic FWD_WB  = 1'b1;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: request handshake, wait counting, timeout fault.
//
// state | meaning
// IDLE  | no access outstanding; a MW load/store issues mem_req this cycle
// WAIT  | access outstanding, waiting for mem_ready; counter holds cycles waited
// FAULT | one-cycle timeout report; writeback of the faulting instruction killed
module mem_access_fsm
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_op,
   input  logic mem_ready,
   output logic mem_req,
   output logic kill_wb,
   output logic mem_fault,
   output logic mem_stall
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   mem_state_t       state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op && !mem_ready) begin
                  state <= WAIT;
                  cnt   <= CNT_W'(1);
               end
            end
            WAIT: begin
               if (mem_ready) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state <= FAULT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            FAULT: begin
               state <= IDLE;
               cnt   <= '0;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Gated by rst so an abandoned access drops mem_req without waiting for a clock
   always_comb begin
      mem_req   = 1'b0;
      kill_wb   = 1'b0;
      mem_fault = 1'b0;
      mem_stall = 1'b0;
      if (rst) begin
         case (state)
            IDLE: begin
               mem_req   = mem_op;
               mem_stall = mem_op & ~mem_ready;
            end
            WAIT: begin
               mem_req   = 1'b1;
               mem_stall = ~mem_ready;
            end
            FAULT: begin
               kill_wb   = 1'b1;
               mem_fault = 1'b1;
            end
            default: begin
               mem_req = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the IF/DE/MW pipeline.
// FWD_EN defined: MW->DE operand forwarding; undefined: one-cycle RAW interlock instead.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1),
   parameter int REG_AW         = REG_AW_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_de,
   input  logic [REG_AW-1:0] rs2_de,
   input  logic [REG_AW-1:0] rd_mw,
   input  logic              reg_wr_mw,
   input  logic              rd_en_mw,
   input  logic              wr_en_mw,
   input  logic              br_taken,
   input  logic              mem_ready,
   output logic              fwd_a,
   output logic              fwd_b,
   output logic              stall_if,
   output logic              stall_de,
   output logic              hold_mw,
   output logic              bubble_mw,
   output logic              flush_if,
   output logic              mem_req,
   output logic              kill_wb,
   output logic              mem_fault
);

   logic mem_op;
   logic mem_stall;
   logic hit_a;
   logic hit_b;
   logic fwd_sel_a;
   logic fwd_sel_b;
   logic raw_ilk;
   logic stall;

   assign mem_op = rd_en_mw | wr_en_mw;

   mem_access_fsm #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .mem_op    (mem_op),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .kill_wb   (kill_wb),
      .mem_fault (mem_fault),
      .mem_stall (mem_stall)
   );

   // x0 is hardwired zero, so a write to it never produces a dependency
   assign hit_a = reg_wr_mw && (rd_mw != '0) && (rd_mw == rs1_de);
   assign hit_b = reg_wr_mw && (rd_mw != '0) && (rd_mw == rs2_de);

`ifdef FWD_EN
   assign fwd_sel_a = hit_a ? FWD_WB : FWD_REG;
   assign fwd_sel_b = hit_b ? FWD_WB : FWD_REG;
   assign raw_ilk   = 1'b0;
`else
   assign fwd_sel_a = FWD_REG;
   assign fwd_sel_b = FWD_REG;
   // Memory stall keeps the writer in MW, so the interlock waits until it can retire
   assign raw_ilk   = (hit_a | hit_b) & ~mem_stall;
`endif

   assign stall = mem_stall | raw_ilk;

   always_comb begin
      fwd_a     = rst & fwd_sel_a;
      fwd_b     = rst & fwd_sel_b;
      stall_if  = rst & stall;
      stall_de  = rst & stall;
      hold_mw   = rst & mem_stall;
      bubble_mw = rst & raw_ilk;
      flush_if  = rst & br_taken & ~stall;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random traffic vs. a cycle model.
module tb_pipe_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int T  = 4;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs1_de, rs2_de, rd_mw;
   logic          reg_wr_mw, rd_en_mw, wr_en_mw, br_taken, mem_ready;
   logic          fwd_a, fwd_b, stall_if, stall_de, hold_mw, bubble_mw;
   logic          flush_if, mem_req, kill_wb, mem_fault;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: cycles already waited on the outstanding access (0 = none)
   int m_wait  = 0;
   bit m_fault = 1'b0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.TIMEOUT_CYCLES(T), .REG_AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .rs1_de    (rs1_de),
      .rs2_de    (rs2_de),
      .rd_mw     (rd_mw),
      .reg_wr_mw (reg_wr_mw),
      .rd_en_mw  (rd_en_mw),
      .wr_en_mw  (wr_en_mw),
      .br_taken  (br_taken),
      .mem_ready (mem_ready),
      .fwd_a     (fwd_a),
      .fwd_b     (fwd_b),
      .stall_if  (stall_if),
      .stall_de  (stall_de),
      .hold_mw   (hold_mw),
      .bubble_mw (bubble_mw),
      .flush_if  (flush_if),
      .mem_req   (mem_req),
      .kill_wb   (kill_wb),
      .mem_fault (mem_fault)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit r, input bit rw, input bit re, input bit we, input bit br,
                        input bit rdy, input int d, input int s1, input int s2);
      rst       = r;
      reg_wr_mw = rw;
      rd_en_mw  = re;
      wr_en_mw  = we;
      br_taken  = br;
      mem_ready = rdy;
      rd_mw     = AW'(d);
      rs1_de    = AW'(s1);
      rs2_de    = AW'(s2);
   endtask

   // Called just after a falling edge with inputs applied; checks, then steps the model
   // across the following rising edge and returns on the next falling edge.
   task automatic tick();
      bit         op, e_req, e_flt, e_kill, e_ms, e_fa, e_fb, e_ilk, e_stall, e_flush;
      bit         h1, h2;
      mem_state_t e_st;
      #1;
      op = rd_en_mw | wr_en_mw;
      e_req = 0; e_flt = 0; e_kill = 0; e_ms = 0; e_fa = 0; e_fb = 0; e_ilk = 0;
      e_stall = 0; e_flush = 0;
      if (!rst) begin
         m_wait  = 0;
         m_fault = 1'b0;
      end else begin
         if (m_fault) begin
            e_flt  = 1;
            e_kill = 1;
         end else if (m_wait > 0) begin
            e_req = 1;
            e_ms  = !mem_ready;
         end else begin
            e_req = op;
            e_ms  = op && !mem_ready;
         end
         h1 = reg_wr_mw && rd_mw != 0 && rd_mw == rs1_de;
         h2 = reg_wr_mw && rd_mw != 0 && rd_mw == rs2_de;
`ifdef FWD_EN
         e_fa = h1;
         e_fb = h2;
`else
         e_ilk = (h1 || h2) && !e_ms;
`endif
         e_stall = e_ms || e_ilk;
         e_flush = br_taken && !e_stall;
      end
      e_st = m_fault ? FAULT : (m_wait > 0 ? WAIT : IDLE);

      check("fwd_a",     32'(fwd_a),     32'(e_fa));
      check("fwd_b",     32'(fwd_b),     32'(e_fb));
      check("stall_if",  32'(stall_if),  32'(e_stall));
      check("stall_de",  32'(stall_de),  32'(e_stall));
      check("hold_mw",   32'(hold_mw),   32'(e_ms));
      check("bubble_mw", 32'(bubble_mw), 32'(e_ilk));
      check("flush_if",  32'(flush_if),  32'(e_flush));
      check("mem_req",   32'(mem_req),   32'(e_req));
      check("kill_wb",   32'(kill_wb),   32'(e_kill));
      check("mem_fault", 32'(mem_fault), 32'(e_flt));
      check("state",     32'(dut.u_fsm.state), 32'(e_st));
      if (!m_fault) check("wait_cnt", 32'(dut.u_fsm.cnt), 32'(m_wait));

      if (rst) begin
         if (m_fault) begin
            m_fault = 1'b0;
            m_wait  = 0;
         end else if (m_wait > 0) begin
            if (mem_ready)      m_wait = 0;
            else if (m_wait == T) begin
               m_fault = 1'b1;
               m_wait  = 0;
            end else            m_wait++;
         end else if (op && !mem_ready) begin
            m_wait = 1;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      tick();                                     // reset state
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      drive(1, 1, 1, 0, 0, 1, 7, 1, 2); tick();   // zero-wait load
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      for (int i = 0; i < 3; i++) begin           // 3-wait store
         drive(1, 0, 0, 1, 0, 0, 0, 0, 0); tick();
      end
      drive(1, 0, 0, 1, 0, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      for (int i = 0; i < T + 1; i++) begin       // timeout: miss + WAIT 1..T
         drive(1, 1, 1, 0, 0, 0, 3, 0, 0); tick();
      end
      drive(1, 1, 1, 0, 0, 0, 3, 0, 0); tick();   // FAULT cycle
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      for (int i = 0; i < T; i++) begin           // ready on the last possible cycle
         drive(1, 1, 1, 0, 0, 0, 3, 0, 0); tick();
      end
      drive(1, 1, 1, 0, 0, 1, 3, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      drive(1, 1, 0, 0, 0, 0, 5, 5, 5); tick();   // forwarding / RAW patterns
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0, 5, 5, 9); tick();
      drive(1, 1, 0, 0, 0, 0, 5, 3, 5); tick();
      drive(1, 0, 0, 0, 0, 0, 5, 5, 5); tick();
      drive(1, 1, 0, 0, 1, 0, 5, 5, 0); tick();   // branch against interlock
      drive(1, 1, 1, 0, 0, 0, 5, 5, 0); tick();   // RAW under memory stall
      drive(1, 1, 1, 0, 0, 1, 5, 5, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      drive(1, 0, 1, 0, 1, 0, 0, 0, 0); tick();   // branch held by 2-cycle wait
      drive(1, 0, 1, 0, 1, 0, 0, 0, 0); tick();
      drive(1, 0, 1, 0, 1, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      for (int i = 0; i < 3; i++) begin           // reach WAIT with counter 3
         drive(1, 0, 0, 1, 0, 0, 0, 0, 0); tick();
      end
      drive(0, 1, 0, 1, 1, 0, 5, 5, 5); tick();   // reset mid-access
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      for (int i = 0; i < 500; i++) begin
         drive($urandom_range(0, 59) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 3-stage pipeline: IF, DE (decode/execute) and MW (memory/writeback).
- Generates operand-forwarding selects, stall/hold/bubble/flush controls for the IF/DE and DE/MW pipeline registers, and the data-memory request handshake.
- Sits beside the DE/MW control pipeline register.
- Sources: its MW-stage control bits (reg_wr, rd_en, wr_en, wb_sel) and DE-stage register addresses. Sinks: the pipeline registers, operand muxes and data memory.

Parameters:
- TIMEOUT_CYCLES, 16, max WAIT cycles before memory fault (>=2).
- CNT_W, $clog2(TIMEOUT_CYCLES+1), wait-counter width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rs1_de  in  REG_AW  DE source 1 address
- rs2_de  in  REG_AW  DE source 2 address
- rd_mw  in  REG_AW  MW destination address
- reg_wr_mw  in  1  MW writes register file
- rd_en_mw  in  1  MW load
- wr_en_mw  in  1  MW store
- br_taken  in  1  DE branch/jump resolved taken
- mem_ready  in  1  data memory completes access this cycle
- fwd_a  out  1  1 = operand A from MW writeback value
- fwd_b  out  1  1 = operand B from MW writeback value
- stall_if  out  1  hold PC and IF/DE register
- stall_de  out  1  hold DE inputs
- hold_mw  out  1  hold DE/MW register
- bubble_mw  out  1  load zeros into DE/MW control
- flush_if  out  1  zero IF/DE register (squash fetched instruction)
- mem_req  out  1  data memory request
- kill_wb  out  1  suppress MW register write
- mem_fault  out  1  one-cycle timeout pulse

Behaviour:
- Reset:
  - rst=0 forces state IDLE and wait counter 0, immediately and asynchronously.
  - All outputs are 0 while rst=0.
  - Reset mid-WAIT abandons the access: mem_req drops asynchronously.
- mem_op = rd_en_mw | wr_en_mw.
- FSM states IDLE, WAIT, FAULT:
  - IDLE:
    - mem_req = mem_op.
    - mem_op & mem_ready: zero-wait access completes, stay IDLE, no stall.
    - mem_op & ~mem_ready: go to WAIT, counter <= 1, stall asserted this cycle.
  - WAIT:
    - mem_req = 1.
    - mem_ready: go to IDLE, counter <= 0; stall outputs 0 that cycle, so the instruction retires.
    - Else, if counter == TIMEOUT_CYCLES: go to FAULT. Otherwise counter++.
    - mem_ready in the timeout cycle: completion wins.
  - FAULT:
    - Lasts one cycle: mem_fault=1, kill_wb=1, mem_req=0, no stall.
    - Always returns to IDLE.
- Memory stall, in IDLE-with-miss and WAIT-without-ready: stall_if = stall_de = hold_mw = 1, bubble_mw = 0.
- Forwarding:
  - fwd_a = reg_wr_mw & (rd_mw != 0) & (rd_mw == rs1_de); fwd_b likewise for rs2_de.
  - Combinational; valid in every state.
- Flush: flush_if = br_taken & ~stall_de.
  - A branch held by a stall flushes on its first unstalled cycle.
  - No flush state is stored.
- Priority: memory stall > RAW interlock > flush.
- All outputs except state and counter are combinational from state and inputs.

Optional Feature:
- Macro: FWD_EN.
- Defined: forwarding as above; RAW interlock never fires.
- Undefined:
  - fwd_a = fwd_b = 0.
  - RAW hazard = reg_wr_mw & (rd_mw != 0) & (rd_mw matches rs1_de or rs2_de).
  - On a RAW hazard without a memory stall: stall_if = stall_de = 1, bubble_mw = 1, hold_mw = 0 for exactly one cycle. The writer retires, and the next cycle sees a bubble in MW.
  - flush_if is suppressed during the interlock.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum (IDLE, WAIT, FAULT).
  - FWD_REG / FWD_WB select constants.
  - REG_AW default.
- Sub-module mem_access_fsm: state, counter, mem_req, kill_wb, mem_fault and the memory-stall term.
- Forwarding, interlock and flush logic stay in the top.

Test Plan:
- Reset mid-access: rst low in WAIT with counter 3 -> mem_req and all stalls 0 immediately; after rst high, state IDLE, counter 0.
- Zero-wait load: rd_en_mw=1 and mem_ready=1 in the same cycle -> mem_req=1, no stall, state stays IDLE.
- 3-wait store: wr_en_mw=1, mem_ready high on the 4th cycle -> stall_if/stall_de/hold_mw=1 for 3 cycles, 0 on the 4th, back to IDLE.
- Timeout, TIMEOUT_CYCLES=4, mem_ready never asserted -> after the IDLE-miss cycle and WAIT with counter 1..4, FAULT follows: mem_fault and kill_wb 1 for exactly one cycle, then IDLE.
  - Repeat with mem_ready asserted in the counter==4 cycle -> no fault.
- Forwarding with FWD_EN: rd_mw=5, reg_wr_mw=1, rs1_de=5, rs2_de=5 -> fwd_a=fwd_b=1.
  - rd_mw=0 -> both 0.
  - Without FWD_EN, rd_mw=5 and rs1_de=5 -> one-cycle stall with bubble_mw=1, no forwarding.
- Branch under stall: br_taken=1 during a 2-cycle memory wait -> flush_if=0 while stalled, 1 in the release cycle.
